// File: rtl/branch_predictor_pkg.sv
// Shared front-end definitions: BTB geometry, entry/update bundles and counter encodings.
package Public_Info;
  localparam int BTB_ENTRIES = 64;
  localparam int BTB_IDX_W   = 6;
  localparam int BTB_TAG_W   = 8;

  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [29:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } btb_upd_t;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state function.
module sat_counter2 (
  input  logic [1:0] i_ctr,
  input  logic       i_up,
  output logic [1:0] o_ctr
);
  always_comb begin
    o_ctr = i_ctr;
    if (i_up) begin
      if (i_ctr != 2'b11) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != 2'b00) o_ctr = i_ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Flop-based BTB next-PC predictor for the dual-fetch pair (pc, pc+4).
// Lookup is combinational; training from EX lands on the next rising clk.
module branch_predictor
  import Public_Info::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = BTB_IDX_W,
  parameter int TAG_W   = BTB_TAG_W   // must equal BTB_TAG_W (entry type is shared)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_pc_fetch,
  output logic [31:0] o_pc_predict,
  output logic [1:0]  o_pd_taken,
  output logic        o_slot1_kill,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  btb_entry_t       r_btb [ENTRIES];
  btb_upd_t         w_upd;
  btb_entry_t       w_e0, w_e1, w_ue;
  logic [31:0]      w_pc1;
  logic [IDX_W-1:0] w_idx0, w_idx1, w_uidx;
  logic [TAG_W-1:0] w_tag0, w_tag1, w_utag;
  logic             w_tk0, w_tk1, w_uhit;
  logic [1:0]       w_ctr_nxt;
  logic             w_unused;

  assign w_upd = '{valid: i_upd_valid, pc: i_upd_pc, taken: i_upd_taken, target: i_upd_target};

  // Lookup: slot1 is pc+4, so its index is always slot0's index + 1 mod ENTRIES.
  assign w_pc1  = i_pc_fetch + 32'd4;
  assign w_idx0 = i_pc_fetch[IDX_W+1:2];
  assign w_tag0 = i_pc_fetch[TAG_HI:TAG_LO];
  assign w_idx1 = w_pc1[IDX_W+1:2];
  assign w_tag1 = w_pc1[TAG_HI:TAG_LO];
  assign w_e0   = r_btb[w_idx0];
  assign w_e1   = r_btb[w_idx1];
  assign w_tk0  = w_e0.valid && (w_e0.tag == w_tag0) && w_e0.ctr[1];
  assign w_tk1  = w_e1.valid && (w_e1.tag == w_tag1) && w_e1.ctr[1];

  always_comb begin
    o_pc_predict = i_pc_fetch + 32'd8;
    o_pd_taken   = 2'b00;
    o_slot1_kill = 1'b0;
    if (w_tk0) begin
      o_pc_predict = {w_e0.target, 2'b00};
      o_pd_taken   = 2'b10;
      o_slot1_kill = 1'b1;
    end else if (w_tk1) begin
      o_pc_predict = {w_e1.target, 2'b00};
      o_pd_taken   = 2'b01;
    end
  end

  // Update path
  assign w_uidx = w_upd.pc[IDX_W+1:2];
  assign w_utag = w_upd.pc[TAG_HI:TAG_LO];
  assign w_ue   = r_btb[w_uidx];
  assign w_uhit = w_ue.valid && (w_ue.tag == w_utag);

  sat_counter2 u_ctr (
    .i_ctr (w_ue.ctr),
    .i_up  (w_upd.taken),
    .o_ctr (w_ctr_nxt)
  );

  // Reads above see pre-edge contents, so a same-cycle lookup gets old data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++)
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
    end else if (w_upd.valid) begin
      if (w_uhit) begin
        r_btb[w_uidx].ctr <= w_ctr_nxt;
        if (w_upd.taken) r_btb[w_uidx].target <= w_upd.target[31:2];
      end else if (w_upd.taken) begin
        r_btb[w_uidx] <= '{valid: 1'b1, tag: w_utag, target: w_upd.target[31:2],
                           ctr: CTR_WEAK_T};
      end
    end
  end

  assign w_unused = ^{w_upd.pc[31:TAG_HI+1], w_upd.pc[1:0], w_upd.target[1:0],
                      w_pc1[31:TAG_HI+1], w_pc1[1:0], i_pc_fetch[31:TAG_HI+1]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] i_pc_fetch = '0;
  logic [31:0] o_pc_predict;
  logic [1:0]  o_pd_taken;
  logic        o_slot1_kill;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic        i_upd_taken = 1'b0;
  logic [31:0] i_upd_target = '0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_pc_fetch   (i_pc_fetch),
    .o_pc_predict (o_pc_predict),
    .o_pd_taken   (o_pd_taken),
    .o_slot1_kill (o_slot1_kill),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .i_upd_target (i_upd_target)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drive a fetch PC (between edges) and check all three outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] exp_pc,
                      input logic [1:0] exp_pd, input logic exp_kill);
    i_pc_fetch = pc;
    #1;
    chk({tag, ".pc"},   o_pc_predict, exp_pc);
    chk({tag, ".pd"},   {30'd0, o_pd_taken}, {30'd0, exp_pd});
    chk({tag, ".kill"}, {31'd0, o_slot1_kill}, {31'd0, exp_kill});
  endtask

  // One resolved-branch update, applied at the next rising edge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    i_upd_valid  = 1'b1;
    i_upd_pc     = pc;
    i_upd_taken  = tk;
    i_upd_target = tgt;
    @(posedge clk); #1;
    i_upd_valid  = 1'b0;
  endtask

  initial begin
    // Held in reset: all entries invalid, sequential guess.
    #2;
    look("rst_lookup", 32'h1C00_0000, 32'h1C00_0008, 2'b00, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    look("post_rst", 32'h1C00_0000, 32'h1C00_0008, 2'b00, 1'b0);

    // Allocate idx 4 / tag 0x00, ctr=10.
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0100);
    look("alloc_s0", 32'h1C00_0010, 32'h1C00_0100, 2'b10, 1'b1);
    look("hit_s1",   32'h1C00_000C, 32'h1C00_0100, 2'b01, 1'b0);

    // Hysteresis: 10 -NT-> 01 (not taken)
    upd(32'h1C00_0010, 1'b0, 32'h0);
    look("ctr01", 32'h1C00_0010, 32'h1C00_0018, 2'b00, 1'b0);
    // 01 -T-> 10 -T-> 11 -T-> 11 (saturate) -NT-> 10 still taken
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0100);
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0100);
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0100);
    upd(32'h1C00_0010, 1'b0, 32'h0);
    look("ctr10", 32'h1C00_0010, 32'h1C00_0100, 2'b10, 1'b1);
    // 10 -NT-> 01: only reachable as not-taken if 11 saturated above
    upd(32'h1C00_0010, 1'b0, 32'h0);
    look("sat_hi", 32'h1C00_0010, 32'h1C00_0018, 2'b00, 1'b0);
    // 01 -NT-> 00 -NT-> 00 -T-> 01 (still not taken)
    upd(32'h1C00_0010, 1'b0, 32'h0);
    upd(32'h1C00_0010, 1'b0, 32'h0);
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0140);
    look("sat_lo", 32'h1C00_0010, 32'h1C00_0018, 2'b00, 1'b0);
    // 01 -T-> 10, target overwritten on taken hit
    upd(32'h1C00_0010, 1'b1, 32'h1C00_0180);
    look("retarget", 32'h1C00_0010, 32'h1C00_0180, 2'b10, 1'b1);

    // Alias: 0x1C000110 has idx 4 but tag pc[15:8]=0x01.
    look("alias_miss", 32'h1C00_0110, 32'h1C00_0118, 2'b00, 1'b0);
    upd(32'h1C00_0110, 1'b1, 32'h1C00_0200);
    look("alias_alloc", 32'h1C00_0110, 32'h1C00_0200, 2'b10, 1'b1);
    look("evicted",     32'h1C00_0010, 32'h1C00_0018, 2'b00, 1'b0);

    // Not-taken miss and invalid update leave the table alone.
    upd(32'h1C00_0040, 1'b0, 32'h1C00_0400);
    look("nt_miss", 32'h1C00_0040, 32'h1C00_0048, 2'b00, 1'b0);
    i_upd_pc = 32'h1C00_0080; i_upd_taken = 1'b1; i_upd_target = 32'h1C00_0800;
    @(posedge clk); #1;
    look("upd_invalid", 32'h1C00_0080, 32'h1C00_0088, 2'b00, 1'b0);

    // Fetch-pair wraps: slot1 = 0x00000000 (idx 0, tag 0).
    upd(32'h0000_0000, 1'b1, 32'h0000_0100);
    look("wrap_s1", 32'hFFFF_FFFC, 32'h0000_0100, 2'b01, 1'b0);

    // Same-cycle update+lookup: old contents now, new after the edge.
    i_upd_valid = 1'b1; i_upd_pc = 32'h1C00_0010; i_upd_taken = 1'b1;
    i_upd_target = 32'h1C00_0300;
    look("war_old", 32'h1C00_0010, 32'h1C00_0018, 2'b00, 1'b0);
    @(posedge clk); #1;
    i_upd_valid = 1'b0;
    look("war_new", 32'h1C00_0010, 32'h1C00_0300, 2'b10, 1'b1);

    // Async reset mid-stream with a pending update that must be dropped.
    i_upd_valid = 1'b1; i_upd_pc = 32'h1C00_0050; i_upd_taken = 1'b1;
    i_upd_target = 32'h1C00_0500;
    #2 rstn = 1'b0;
    look("rst_async", 32'h1C00_0010, 32'h1C00_0018, 2'b00, 1'b0);
    @(posedge clk); #1;
    i_upd_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    look("rst_drop", 32'h1C00_0050, 32'h1C00_0058, 2'b00, 1'b0);
    look("rst_wrap", 32'hFFFF_FFFC, 32'h0000_0004, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
